// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction memory writes, holding the core in reset until done.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_BYTES, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_BYTES, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_word;
  logic              accept;
  logic              len_bad;
  logic              last_word;
  logic              load_go;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = byte_valid && byte_ready;
  assign len_bad   = (byte_data == 8'd0) || (int'({24'd0, byte_data}) > DEPTH);
  assign last_word = ((word_count + CNT_ONE) == len_q);
  assign load_go   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN;
      S_LEN:   if (accept) state_nxt = len_bad ? S_ERR : S_BYTES;
      S_BYTES: if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: state_nxt = last_word ? S_CHK : S_BYTES;
      S_CHK:   if (accept) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
`else
      S_WRITE: state_nxt = last_word ? S_DONE : S_BYTES;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // All handshake/status outputs decode the registered state only.
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state)
      S_LEN, S_BYTES: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      S_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly, then the completed word is registered for the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      byte_cnt   <= 2'd0;
      asm_word   <= 24'd0;
      wr_data    <= 32'd0;
      wr_addr    <= '0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else if (load_go) begin
      byte_cnt   <= 2'd0;
      wr_addr    <= '0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      case (state)
        S_LEN: if (accept && !len_bad) len_q <= (ADDR_W+1)'(byte_data);
        S_BYTES: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ byte_data;
`endif
          case (byte_cnt)
            2'd0:    asm_word[7:0]   <= byte_data;
            2'd1:    asm_word[15:8]  <= byte_data;
            2'd2:    asm_word[23:16] <= byte_data;
            default: wr_data <= {byte_data, asm_word};
          endcase
        end
        S_WRITE: begin
          word_count <= word_count + CNT_ONE;
          // Address stays on N-1 after the final write so it never wraps.
          if (!last_word) wr_addr <= wr_addr + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
